midi_port: RTL and testbench

- One full-duplex MIDI serial port: 8N1 UART transmitter and receiver, plus per-direction activity indicators for LEDs.
- Instantiated as an array, one per physical MIDI port, inside the router top level.
- The host presents bytes on a parallel interface. The port serialises them onto the output line and deserialises the input line into byte strobes.

---
 rtl/midi_pkg.sv | 23 ++
 rtl/midi_uart_rx.sv | 123 ++++++++++++
 rtl/midi_port.sv | 167 ++++++++++++++++
 tb/tb_midi_port.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI port: 8N1 frame constants and the TX/RX FSM state types.
// No ports; imported by midi_uart_rx and midi_port.
package midi_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        STOP_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitIdle
  } rx_state_e;

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 UART receiver for one MIDI input line.
// Ports:
//   clk_i     system clock
//   rst_ni    synchronous active-low reset
//   rx_i      asynchronous serial input, idle high
//   rxdv_o    one-cycle strobe, rxdata_o holds a freshly received byte
//   rxdata_o  last correctly framed byte
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 384
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 rxdv_o,
  output logic [DATA_BITS-1:0] rxdata_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] LastBit = IdxW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, prev_q;
  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // Synchroniser resets to the idle level so reset release is not seen as a start edge.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (prev_q && !sync2_q) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        // Re-check at mid start bit; a high line here means the edge was a glitch.
        if (cnt_q == HalfEnd) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sync2_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (idx_q == LastBit) begin
            state_d = RxStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == BitEnd) begin
          cnt_d = '0;
          if (sync2_q == STOP_LEVEL) begin
            data_d  = shift_q;
            dv_d    = 1'b1;
            state_d = RxIdle;
          end else begin
            // Framing error: drop the byte and wait for the line to recover.
            state_d = RxWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxWaitIdle: begin
        if (sync2_q) begin
          state_d = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign rxdv_o   = dv_q;
  assign rxdata_o = data_q;

endmodule

// File: rtl/midi_port.sv
// One full-duplex MIDI port: 8N1 transmitter, receiver and stretched activity indicators.
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   txdv         transmit request level; a rising edge while idle starts a frame
//   outport      serial MIDI out, idle high
//   txdata       byte to send, latched on an accepted txdv edge
//   rxdv         one-cycle strobe for a new received byte
//   inport       asynchronous serial MIDI in, idle high
//   rxdata       last correctly framed received byte
//   activity_in  high while receive activity is stretched
//   activity_out high while transmit activity is stretched
//   txcurport    port tag latched with each accepted byte (not sent on the line)
module midi_port
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 384,
  parameter int unsigned ACT_CYCLES   = 600000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txdv,
  output logic       outport,
  input  logic [7:0] txdata,
  output logic       rxdv,
  input  logic       inport,
  output logic [7:0] rxdata,
  output logic       activity_in,
  output logic       activity_out,
  input  logic [3:0] txcurport
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam int unsigned ActW = $clog2(ACT_CYCLES + 1);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastBit = IdxW'(DATA_BITS - 1);
  localparam logic [ActW-1:0] ActLoad = ActW'(ACT_CYCLES);

  logic                 txdv_q;
  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [IdxW-1:0]      tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 out_q, out_d;
  // Routing/debug tag; nothing in this block consumes it.
  logic [3:0]           txcurport_unused_q, txcurport_unused_d;
  logic [ActW-1:0]      act_in_q, act_in_d;
  logic [ActW-1:0]      act_out_q, act_out_d;
  logic                 tx_start;

  midi_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk_i    (clk),
    .rst_ni   (rst),
    .rx_i     (inport),
    .rxdv_o   (rxdv),
    .rxdata_o (rxdata)
  );

  // Edges arriving while a frame is in flight are dropped, not queued.
  assign tx_start = (tx_state_q == TxIdle) && txdv && !txdv_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      txdv_q             <= 1'b0;
      tx_state_q         <= TxIdle;
      tx_cnt_q           <= '0;
      tx_idx_q           <= '0;
      tx_data_q          <= '0;
      out_q              <= 1'b1;
      txcurport_unused_q <= '0;
      act_in_q           <= '0;
      act_out_q          <= '0;
    end else begin
      txdv_q             <= txdv;
      tx_state_q         <= tx_state_d;
      tx_cnt_q           <= tx_cnt_d;
      tx_idx_q           <= tx_idx_d;
      tx_data_q          <= tx_data_d;
      out_q              <= out_d;
      txcurport_unused_q <= txcurport_unused_d;
      act_in_q           <= act_in_d;
      act_out_q          <= act_out_d;
    end
  end

  // out_q is registered, so each bit level is set on the last cycle of the previous bit.
  always_comb begin
    tx_state_d         = tx_state_q;
    tx_cnt_d           = tx_cnt_q;
    tx_idx_d           = tx_idx_q;
    tx_data_d          = tx_data_q;
    out_d              = out_q;
    txcurport_unused_d = txcurport_unused_q;
    unique case (tx_state_q)
      TxIdle: begin
        if (tx_start) begin
          tx_state_d         = TxStart;
          tx_cnt_d           = '0;
          tx_data_d          = txdata;
          txcurport_unused_d = txcurport;
          out_d              = 1'b0;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          out_d      = tx_data_q[0];
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_d = '0;
          if (tx_idx_q == LastBit) begin
            out_d      = STOP_LEVEL;
            tx_state_d = TxStop;
          end else begin
            tx_idx_d  = tx_idx_q + 1'b1;
            out_d     = tx_data_q[1];
            tx_data_d = tx_data_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_d   = '0;
          tx_state_d = TxIdle;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = TxIdle;
        out_d      = 1'b1;
      end
    endcase
  end

  // Retrigger reloads the full count, so back-to-back traffic keeps the LED solid.
  always_comb begin
    act_in_d  = act_in_q;
    act_out_d = act_out_q;
    if (rxdv) begin
      act_in_d = ActLoad;
    end else if (act_in_q != '0) begin
      act_in_d = act_in_q - 1'b1;
    end
    if (tx_start) begin
      act_out_d = ActLoad;
    end else if (act_out_q != '0) begin
      act_out_d = act_out_q - 1'b1;
    end
  end

  assign outport      = out_q;
  assign activity_in  = (act_in_q != '0);
  assign activity_out = (act_out_q != '0);

endmodule

// File: tb/tb_midi_port.sv
// Directed-plus-random bench for midi_port with CLKS_PER_BIT=2, ACT_CYCLES=8.
module tb_midi_port;

  localparam int unsigned CPB = 2;
  localparam int unsigned ACT = 8;

  logic       clk = 1'b0;
  logic       rst, txdv, inport_drv, loop_en;
  logic [7:0] txdata;
  logic [3:0] txcurport;
  logic       outport, rxdv, activity_in, activity_out;
  logic [7:0] rxdata;
  logic       inport;

  always #5 clk = ~clk;

  assign inport = loop_en ? outport : inport_drv;

  midi_port #(
    .CLKS_PER_BIT (CPB),
    .ACT_CYCLES   (ACT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .txdv         (txdv),
    .outport      (outport),
    .txdata       (txdata),
    .rxdv         (rxdv),
    .inport       (inport),
    .rxdata       (rxdata),
    .activity_in  (activity_in),
    .activity_out (activity_out),
    .txcurport    (txcurport)
  );

  int         n_pass = 0;
  int         n_total = 0;
  int         rxdv_double = 0;
  logic       rxdv_prev = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] last_rx;

  // Collect every received byte; flag any strobe lasting more than one cycle.
  always @(negedge clk) begin
    if (rxdv) rx_q.push_back(rxdata);
    if (rxdv && rxdv_prev) rxdv_double <= rxdv_double + 1;
    rxdv_prev <= rxdv;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends d and checks the whole line waveform: start 0, 8 data bits LSB first, stop 1.
  task automatic tx_frame(input logic [7:0] d, input bit hold, input bit busy_edge);
    logic [9:0] bits;
    logic       exp_line;
    bits = {1'b1, d, 1'b0};
    @(negedge clk);
    txdata    = d;
    txcurport = 4'($urandom);
    txdv      = 1'b1;
    for (int j = 0; j < int'(10 * CPB) + 1; j++) begin
      @(negedge clk);
      exp_line = (j < int'(10 * CPB)) ? bits[j / int'(CPB)] : 1'b1;
      chk("tx_line", 32'(outport), 32'(exp_line));
      chk("act_out", 32'(activity_out), 32'(j < int'(ACT)));
      if (!hold && j == 0) txdv = 1'b0;
      if (busy_edge && j == 6) txdv = 1'b0;
      if (busy_edge && j == 8) txdv = 1'b1;
    end
    if (hold || busy_edge) begin
      for (int j = 0; j < int'(3 * CPB); j++) begin
        @(negedge clk);
        chk("tx_no_retx", 32'(outport), 32'd1);
      end
      txdv = 1'b0;
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      inport_drv = bits[k];
      tick(CPB);
    end
    inport_drv = 1'b1;
  endtask

  // Reference: a frame with a high stop bit yields exactly that byte, otherwise nothing.
  task automatic rx_expect(input logic [7:0] d, input logic stop);
    if (stop) last_rx = d;
    chk("rx_count", 32'(rx_q.size()), stop ? 32'd1 : 32'd0);
    chk("rx_data", 32'(rxdata), 32'(last_rx));
  endtask

  initial begin
    logic [7:0] d;
    logic       s;
    rst        = 1'b0;
    txdv       = 1'b0;
    txdata     = 8'h00;
    txcurport  = 4'h0;
    inport_drv = 1'b1;
    loop_en    = 1'b0;
    last_rx    = 8'h00;
    tick(3);
    chk("rst_outport", 32'(outport), 32'd1);
    chk("rst_rxdv", 32'(rxdv), 32'd0);
    chk("rst_rxdata", 32'(rxdata), 32'h00);
    chk("rst_act_in", 32'(activity_in), 32'd0);
    chk("rst_act_out", 32'(activity_out), 32'd0);
    rst = 1'b1;
    tick(2);

    // Transmit 0xF8 with txdv left high afterwards.
    tx_frame(8'hF8, 1'b1, 1'b0);
    tick(2);

    // Loopback: 0x90 first, then random bytes.
    loop_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? 8'h90 : 8'($urandom);
      rx_q.delete();
      tx_frame(d, 1'b0, 1'b0);
      tick(6);
      rx_expect(d, 1'b1);
      chk("act_in_on", 32'(activity_in), 32'd1);
    end
    loop_en    = 1'b0;
    inport_drv = 1'b1;
    tick(12);
    chk("act_in_off", 32'(activity_in), 32'd0);

    // Framing error, then a good frame.
    rx_q.delete();
    rx_frame(8'h55, 1'b0);
    tick(8);
    rx_expect(8'h55, 1'b0);
    rx_q.delete();
    rx_frame(8'h3C, 1'b1);
    tick(8);
    rx_expect(8'h3C, 1'b1);

    // Random bytes with random stop level.
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      rx_q.delete();
      rx_frame(d, s);
      tick(8);
      rx_expect(d, s);
    end

    // One-cycle glitch must not produce a byte; RX must still receive afterwards.
    rx_q.delete();
    inport_drv = 1'b0;
    tick(1);
    inport_drv = 1'b1;
    tick(10);
    rx_expect(8'h00, 1'b0);
    d = 8'($urandom);
    rx_q.delete();
    rx_frame(d, 1'b1);
    tick(8);
    rx_expect(d, 1'b1);

    // Edge mid-frame is ignored.
    tx_frame(8'($urandom), 1'b1, 1'b1);
    tick(2);

    // Reset mid-frame aborts the frame at once.
    txdata = 8'h00;
    txdv   = 1'b1;
    tick(1);
    txdv = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(1);
    chk("rst_mid_line", 32'(outport), 32'd1);
    chk("rst_mid_act", 32'(activity_out), 32'd0);
    chk("rst_mid_rxdata", 32'(rxdata), 32'h00);
    last_rx = 8'h00;
    rst = 1'b1;
    tick(2);
    tx_frame(8'($urandom), 1'b0, 1'b0);
    tick(2);

    chk("rxdv_single", 32'(rxdv_double), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
